// File: rtl/milano_pkg.sv
// Shared milano definitions for the integer register file.
// Holds default register-file sizes and the register address type.
package milano_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;
    localparam int RF_ADDR_W   = 5;

    typedef logic [RF_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: per-register saturating counters, issue ready,
// busy per read port and sticky underflow flag. Option: MILANO_RF_BYPASS_EN.
module rf_scoreboard
    import milano_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int MAX_PEND = 3,
    parameter int NUM_RD   = 2,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD-1:0]        busy,
    input  logic                     issue_valid,
    input  logic                     issue_wr_en,
    input  logic [ADDR_W-1:0]        issue_rd,
    output logic                     issue_ready,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic                     flush,
    output logic                     err_underflow
);

    localparam int CW = $clog2(MAX_PEND + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PEND);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] cnt     [NUM_REGS];
    logic [CW-1:0] cnt_nxt [NUM_REGS];
    logic          fire;
    logic          flush_q;
    logic          underflow_hit;

    // Issue is refused only while the destination counter is saturated
    always_comb begin
        issue_ready = 1'b1;
        if (issue_wr_en && (cnt[issue_rd] == CNT_MAX)) begin
            issue_ready = 1'b0;
        end
    end

    assign fire = issue_valid & issue_ready & issue_wr_en;

    // Writeback to an idle register, ignored around a flush
    assign underflow_hit = we && (waddr != '0) && (cnt[waddr] == '0)
                           && !flush && !flush_q;

    // Next counter values: flush wins, then inc/dec cancel or step by one
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_nxt[r] = cnt[r];
            if (flush) begin
                cnt_nxt[r] = '0;
            end else if (r != 0) begin
                if (fire && (issue_rd == ADDR_W'(r))
                    && !(we && (waddr == ADDR_W'(r)) && (cnt[r] != '0))) begin
                    cnt_nxt[r] = cnt[r] + CNT_ONE;
                end else if (!(fire && (issue_rd == ADDR_W'(r)))
                    && we && (waddr == ADDR_W'(r)) && (cnt[r] != '0)) begin
                    cnt_nxt[r] = cnt[r] - CNT_ONE;
                end
            end
        end
    end

    // Counter state, flush history and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
            flush_q       <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
            flush_q <= flush;
            if (underflow_hit) begin
                err_underflow <= 1'b1;
            end
        end
    end

    // Busy per read port; with bypass the writeback hit is subtracted
    always_comb begin
        busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
`ifdef MILANO_RF_BYPASS_EN
            if (we && (waddr == raddr[k*ADDR_W +: ADDR_W])
                && (cnt[raddr[k*ADDR_W +: ADDR_W]] != '0)) begin
                busy[k] = cnt[raddr[k*ADDR_W +: ADDR_W]] > CNT_ONE;
            end else begin
                busy[k] = cnt[raddr[k*ADDR_W +: ADDR_W]] != '0;
            end
`else
            busy[k] = cnt[raddr[k*ADDR_W +: ADDR_W]] != '0;
`endif
            if (raddr[k*ADDR_W +: ADDR_W] == '0) begin
                busy[k] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/regs_file_sb.sv
// Integer register file with NUM_RD read ports and a pending-write scoreboard.
// Option: MILANO_RF_BYPASS_EN enables same-cycle write-through on reads.
module regs_file_sb
    import milano_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int MAX_PEND = 3,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
    output logic [NUM_RD*DATA_W-1:0] rdata_o,
    output logic [NUM_RD-1:0]        busy_o,
    input  logic                     issue_valid_i,
    input  logic                     issue_wr_en_i,
    input  logic [ADDR_W-1:0]        issue_rd_i,
    output logic                     issue_ready_o,
    input  logic                     we_i,
    input  logic [ADDR_W-1:0]        waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic                     flush_i,
    output logic                     err_underflow_o
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Data array; x0 is never written so it stays zero
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs[waddr_i] <= wdata_i;
        end
    end

    // Combinational read muxes, x0 forced to zero
    always_comb begin
        rdata_o = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (raddr_i[k*ADDR_W +: ADDR_W] != '0) begin
                rdata_o[k*DATA_W +: DATA_W] = regs[raddr_i[k*ADDR_W +: ADDR_W]];
`ifdef MILANO_RF_BYPASS_EN
                if (we_i && (waddr_i == raddr_i[k*ADDR_W +: ADDR_W])) begin
                    rdata_o[k*DATA_W +: DATA_W] = wdata_i;
                end
`endif
            end
        end
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .MAX_PEND (MAX_PEND),
        .NUM_RD   (NUM_RD),
        .ADDR_W   (ADDR_W)
    ) u_sb (
        .clk           (clk_i),
        .rst_n         (rst_ni),
        .raddr         (raddr_i),
        .busy          (busy_o),
        .issue_valid   (issue_valid_i),
        .issue_wr_en   (issue_wr_en_i),
        .issue_rd      (issue_rd_i),
        .issue_ready   (issue_ready_o),
        .we            (we_i),
        .waddr         (waddr_i),
        .flush         (flush_i),
        .err_underflow (err_underflow_o)
    );

endmodule

// File: tb/tb_regs_file_sb.sv
// Directed self-checking bench for regs_file_sb (MAX_PEND=3, two read ports).
// Expectations follow MILANO_RF_BYPASS_EN when it is defined.
module tb_regs_file_sb;
    import milano_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  busy;
    logic        issue_valid;
    logic        issue_wr_en;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        flush;
    logic        err;

    int total = 0;
    int bad   = 0;

    regs_file_sb dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .raddr_i         (raddr),
        .rdata_o         (rdata),
        .busy_o          (busy),
        .issue_valid_i   (issue_valid),
        .issue_wr_en_i   (issue_wr_en),
        .issue_rd_i      (issue_rd),
        .issue_ready_o   (issue_ready),
        .we_i            (we),
        .waddr_i         (waddr),
        .wdata_i         (wdata),
        .flush_i         (flush),
        .err_underflow_o (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid = 1'b1;
        issue_wr_en = 1'b1;
        issue_rd    = rd;
        step();
        issue_valid = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        step();
        we = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        raddr       = '0;
        issue_valid = 1'b0;
        issue_wr_en = 1'b0;
        issue_rd    = '0;
        we          = 1'b0;
        waddr       = '0;
        wdata       = '0;
        flush       = 1'b0;
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_ready", 64'(issue_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: reset mid-run
        wr(5'd5, 32'hA5A5A5A5);
        raddr[4:0] = 5'd5;
        #1;
        chk("t1_wr_x5", 64'(rdata[31:0]), 64'hA5A5A5A5);
        rst_n = 1'b0;
        #1;
        chk("t1_rst_x5", 64'(rdata[31:0]), 64'd0);
        chk("t1_rst_busy", 64'(busy), 64'd0);
        chk("t1_rst_err", 64'(err), 64'd0);
        rst_n = 1'b1;
        step();

        // 2: single pending write and its writeback
        issue(5'd3);
        raddr[4:0] = 5'd3;
        #1;
        chk("t2_busy_x3", 64'(busy[0]), 64'd1);
        we    = 1'b1;
        waddr = 5'd3;
        wdata = 32'h11;
        #1;
`ifdef MILANO_RF_BYPASS_EN
        chk("t2_wb_busy", 64'(busy[0]), 64'd0);
        chk("t2_wb_data", 64'(rdata[31:0]), 64'h11);
`else
        chk("t2_wb_busy", 64'(busy[0]), 64'd1);
        chk("t2_wb_data", 64'(rdata[31:0]), 64'd0);
`endif
        step();
        we = 1'b0;
        #1;
        chk("t2_after_busy", 64'(busy[0]), 64'd0);
        chk("t2_after_data", 64'(rdata[31:0]), 64'h11);
        chk("t2_err", 64'(err), 64'd0);

        // 3: saturation and simultaneous inc/dec
        for (int i = 0; i < 3; i++) issue(5'd7);
        issue_wr_en = 1'b1;
        issue_rd    = 5'd7;
        raddr[4:0]  = 5'd7;
        #1;
        chk("t3_sat_x7", 64'(issue_ready), 64'd0);
        chk("t3_busy_x7", 64'(busy[0]), 64'd1);
        issue_rd = 5'd8;
        #1;
        chk("t3_ready_x8", 64'(issue_ready), 64'd1);
        issue_rd = 5'd7;
        wr(5'd7, 32'h77);
        #1;
        chk("t3_cnt2_ready", 64'(issue_ready), 64'd1);
        chk("t3_data_x7", 64'(rdata[31:0]), 64'h77);
        we          = 1'b1;
        waddr       = 5'd7;
        wdata       = 32'h78;
        issue_valid = 1'b1;
        step();
        we          = 1'b0;
        issue_valid = 1'b0;
        #1;
        chk("t3_incdec_ready", 64'(issue_ready), 64'd1);
        issue(5'd7);
        #1;
        chk("t3_resat_x7", 64'(issue_ready), 64'd0);

        // 4: flush cancels pending marks, stray write is legal
        issue(5'd4);
        issue(5'd9);
        raddr = {5'd9, 5'd4};
        #1;
        chk("t4_busy_pre", 64'(busy), 64'b11);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        chk("t4_busy_post", 64'(busy), 64'b00);
        chk("t4_ready_x7", 64'(issue_ready), 64'd1);
        wr(5'd4, 32'h22);
        #1;
        chk("t4_data_x4", 64'(rdata[31:0]), 64'h22);
        chk("t4_err", 64'(err), 64'd0);

        // 5: underflow is sticky
        wr(5'd6, 32'h66);
        raddr[4:0] = 5'd6;
        #1;
        chk("t5_data_x6", 64'(rdata[31:0]), 64'h66);
        chk("t5_err", 64'(err), 64'd1);
        step();
        chk("t5_err_sticky", 64'(err), 64'd1);

        // 6: x0 is hardwired
        raddr       = '0;
        we          = 1'b1;
        waddr       = 5'd0;
        wdata       = 32'hFFFFFFFF;
        issue_valid = 1'b1;
        issue_wr_en = 1'b1;
        issue_rd    = 5'd0;
        #1;
        chk("t6_ready_x0", 64'(issue_ready), 64'd1);
        chk("t6_wb_rdata", rdata, 64'd0);
        step();
        we          = 1'b0;
        issue_valid = 1'b0;
        #1;
        chk("t6_rdata", rdata, 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
